// File: rtl/ctrl_cas_sched_if.sv
// ACT-stage request and CAS-issue signals between burst_act, the CAS scheduler and the command encoder.
interface ctrl_cas_sched_if #(
  parameter int unsigned BG_W = 2
);
  logic            act_valid;
  logic            act_hit;
  logic [2:0]      act_rw;
  logic [BG_W-1:0] act_bg;
  logic            act_ready;
  logic            cas_rdy;
  logic [2:0]      cas_req;
  logic [BG_W-1:0] cas_bg;

  modport master (
    output act_valid, act_hit, act_rw, act_bg,
    input  act_ready, cas_rdy, cas_req, cas_bg
  );

  modport slave (
    input  act_valid, act_hit, act_rw, act_bg,
    output act_ready, cas_rdy, cas_req, cas_bg
  );
endinterface

// File: rtl/ctrl_cas_sched.sv
// DDR4 CAS scheduler: in-order column-request queue that enforces tRCD-AL,
// tCCD_S/tCCD_L and read/write turnaround spacing.
module ctrl_cas_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BG_W    = 2,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned T_RCD   = 16,
  parameter int unsigned T_CCD_S = 4,
  parameter int unsigned T_CCD_L = 6,
  parameter int unsigned T_WTR   = 4
) (
  input  logic                       CK_t,
  input  logic                       reset_n,
  ctrl_cas_sched_if.slave            bus,
  input  logic [4:0]                 CL,
  input  logic [4:0]                 CWL,
  input  logic [4:0]                 AL,
  input  logic [3:0]                 BL,
  output logic                       cas_idle,
  output logic [$clog2(DEPTH+1)-1:0] q_level,
  output logic                       err
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
  localparam int unsigned GW      = CNT_W + 1;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [2:0] RD_R  = 3'd0;
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  typedef enum logic [1:0] {CAS_IDLE, CAS_WAIT, CAS_CMD} state_e;

  state_e state_q, state_d;

  logic [2:0]       q_rw  [DEPTH];
  logic [BG_W-1:0]  q_bg  [DEPTH];
  logic [CNT_W-1:0] q_cnt [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q, level_d;

  logic             act_ready_q, cas_rdy_q, cas_idle_q, err_q;
  logic [2:0]       cas_req_q;
  logic [BG_W-1:0]  cas_bg_q;

  logic             has_prev, last_wr;
  logic [BG_W-1:0]  last_bg;
  logic [CNT_W-1:0] since_cas;

  logic             code_ok, push, pop, rcd_ok, gap_ok, head_wr;
  logic [2:0]       head_rw;
  logic [BG_W-1:0]  head_bg;
  logic [CNT_W-1:0] push_cnt, gap;
  logic signed [GW-1:0] rcd_raw, gap_raw;

  function automatic logic is_wr(input logic [2:0] code);
    return (code == WR_R) || (code == WRA_R);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push acceptance and the per-entry countdown loaded on push (eligible delay minus one).
  always_comb begin
    code_ok = (bus.act_rw == RD_R) || (bus.act_rw == RDA_R) ||
              (bus.act_rw == WR_R) || (bus.act_rw == WRA_R);
    push    = bus.act_valid && act_ready_q && code_ok;
    pop     = (state_q == CAS_CMD);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    rcd_raw = signed'(GW'(T_RCD)) - signed'(GW'(AL));
    if (bus.act_hit || (rcd_raw < signed'(GW'(2)))) push_cnt = CNT_W'(1);
    else                                             push_cnt = CNT_W'(rcd_raw - signed'(GW'(1)));
  end

  // Spacing required between the last issued CAS and the current head.
  always_comb begin
    head_rw = q_rw[rd_ptr];
    head_bg = q_bg[rd_ptr];
    head_wr = is_wr(head_rw);
    if (head_wr == last_wr)
      gap_raw = (head_bg == last_bg) ? signed'(GW'(T_CCD_L)) : signed'(GW'(T_CCD_S));
    else if (!last_wr)
      gap_raw = signed'(GW'(CL)) - signed'(GW'(CWL)) + signed'(GW'(BL >> 1)) + signed'(GW'(2));
    else
      gap_raw = signed'(GW'(CWL)) + signed'(GW'(BL >> 1)) + signed'(GW'(T_WTR));
    if (gap_raw < signed'(GW'(T_CCD_S)))      gap = CNT_W'(T_CCD_S);
    else if (gap_raw > signed'(GW'(CNT_MAX))) gap = CNT_W'(CNT_MAX);
    else                                      gap = gap_raw[CNT_W-1:0];
    // Decision is made one cycle ahead of the strobe, hence the minus-one thresholds.
    gap_ok = !has_prev || (since_cas == CNT_W'(CNT_MAX)) || (since_cas >= gap - CNT_W'(1));
    rcd_ok = (q_cnt[rd_ptr] <= CNT_W'(1));
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) state_q <= CAS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAS_IDLE: if (push) state_d = CAS_WAIT;
      CAS_WAIT: if (rcd_ok && gap_ok) state_d = CAS_CMD;
      CAS_CMD:  state_d = (level_d != '0) ? CAS_WAIT : CAS_IDLE;
      default:  state_d = CAS_IDLE;
    endcase
  end

  // Queue storage; every entry's tRCD countdown runs regardless of its position.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_rw[i]  <= '0;
        q_bg[i]  <= '0;
        q_cnt[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++)
        if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - CNT_W'(1);
      if (push) begin
        q_rw[wr_ptr]  <= bus.act_rw;
        q_bg[wr_ptr]  <= bus.act_bg;
        q_cnt[wr_ptr] <= push_cnt;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      level_q <= level_d;
    end
  end

  // Last-issued CAS history and saturating elapsed counter.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      has_prev  <= 1'b0;
      last_wr   <= 1'b0;
      last_bg   <= '0;
      since_cas <= '0;
    end else if (pop) begin
      has_prev  <= 1'b1;
      last_wr   <= head_wr;
      last_bg   <= head_bg;
      since_cas <= CNT_W'(1);
    end else if (since_cas != CNT_W'(CNT_MAX)) begin
      since_cas <= since_cas + CNT_W'(1);
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      act_ready_q <= 1'b1;
      cas_rdy_q   <= 1'b0;
      cas_req_q   <= '0;
      cas_bg_q    <= '0;
      cas_idle_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      act_ready_q <= (level_d < LVL_W'(DEPTH));
      cas_rdy_q   <= (state_d == CAS_CMD);
      cas_idle_q  <= (state_d == CAS_IDLE);
      if (state_d == CAS_CMD) begin
        cas_req_q <= head_rw;
        cas_bg_q  <= head_bg;
      end
      if (bus.act_valid && !push) err_q <= 1'b1;
    end
  end

  assign bus.act_ready = act_ready_q;
  assign bus.cas_rdy   = cas_rdy_q;
  assign bus.cas_req   = cas_req_q;
  assign bus.cas_bg    = cas_bg_q;
  assign cas_idle      = cas_idle_q;
  assign q_level       = level_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// Directed bench for ctrl_cas_sched: vector table of one/two-request scenarios
// plus hand sequences for queue-full, illegal code and mid-run reset.
module tb_ctrl_cas_sched;

  localparam logic [2:0] RD_R  = 3'd0;
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  logic       CK_t;
  logic       reset_n;
  logic [4:0] CL, CWL, AL;
  logic [3:0] BL;
  logic       cas_idle;
  logic [2:0] q_level;
  logic       err;

  int total = 0;
  int bad   = 0;

  ctrl_cas_sched_if #(.BG_W(2)) bus ();

  ctrl_cas_sched #(
    .DEPTH(4), .BG_W(2), .CNT_W(7), .T_RCD(16),
    .T_CCD_S(4), .T_CCD_L(6), .T_WTR(4)
  ) dut (
    .CK_t    (CK_t),
    .reset_n (reset_n),
    .bus     (bus),
    .CL      (CL),
    .CWL     (CWL),
    .AL      (AL),
    .BL      (BL),
    .cas_idle(cas_idle),
    .q_level (q_level),
    .err     (err)
  );

  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  typedef struct {
    logic       two;
    logic       h0;
    logic [2:0] rw0;
    logic [1:0] bg0;
    logic       h1;
    logic [2:0] rw1;
    logic [1:0] bg1;
    logic [4:0] al;
    int         e0;
    int         e1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.act_valid = 1'b0;
    bus.act_hit   = 1'b0;
    bus.act_rw    = RD_R;
    bus.act_bg    = 2'd0;
  endtask

  task automatic drive_push(input logic hit, input logic [2:0] rw, input logic [1:0] bg);
    bus.act_valid = 1'b1;
    bus.act_hit   = hit;
    bus.act_rw    = rw;
    bus.act_bg    = bg;
  endtask

  task automatic do_reset(input logic [4:0] al);
    drive_idle();
    CL = 5'd16; CWL = 5'd12; AL = al; BL = 4'd8;
    reset_n = 1'b0;
    repeat (3) @(posedge CK_t);
    @(negedge CK_t);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_act_ready"}, int'(bus.act_ready), 1);
    check({tag, "_cas_rdy"},   int'(bus.cas_rdy),   0);
    check({tag, "_cas_req"},   int'(bus.cas_req),   0);
    check({tag, "_cas_bg"},    int'(bus.cas_bg),    0);
    check({tag, "_cas_idle"},  int'(cas_idle),      1);
    check({tag, "_q_level"},   int'(q_level),       0);
    check({tag, "_err"},       int'(err),           0);
  endtask

  // One or two requests at cycles 0/1; record when the strobes appear.
  task automatic run_vec(input vec_t v, input int idx);
    int got[2];
    int req[2];
    int bgs[2];
    int n;
    got = '{-1, -1}; req = '{-1, -1}; bgs = '{-1, -1}; n = 0;
    do_reset(v.al);
    for (int k = 0; k < 60; k++) begin
      @(negedge CK_t);
      if (bus.cas_rdy) begin
        if (n < 2) begin
          got[n] = k; req[n] = int'(bus.cas_req); bgs[n] = int'(bus.cas_bg);
        end
        n++;
      end
      if (k == 0)              drive_push(v.h0, v.rw0, v.bg0);
      else if (k == 1 && v.two) drive_push(v.h1, v.rw1, v.bg1);
      else                     drive_idle();
    end
    check($sformatf("v%0d_strobes", idx), n, v.two ? 2 : 1);
    check($sformatf("v%0d_cyc0", idx), got[0], v.e0);
    check($sformatf("v%0d_req0", idx), req[0], int'(v.rw0));
    check($sformatf("v%0d_bg0", idx),  bgs[0], int'(v.bg0));
    if (v.two) begin
      check($sformatf("v%0d_cyc1", idx), got[1], v.e1);
      check($sformatf("v%0d_req1", idx), req[1], int'(v.rw1));
      check($sformatf("v%0d_bg1", idx),  bgs[1], int'(v.bg1));
    end
  endtask

  initial begin
    int strobe_cyc[$];
    int max_lvl;
    int n;
    int exp_cyc[4];

    //            two   h0    rw0    bg0   h1    rw1    bg1   al    e0  e1
    vecs[0] = '{1'b0, 1'b0, RD_R,  2'd0, 1'b0, RD_R,  2'd0, 5'd0, 16, -1};
    vecs[1] = '{1'b1, 1'b1, RD_R,  2'd0, 1'b1, RD_R,  2'd0, 5'd0, 2,  8};
    vecs[2] = '{1'b1, 1'b1, RD_R,  2'd0, 1'b1, RD_R,  2'd1, 5'd0, 2,  6};
    vecs[3] = '{1'b1, 1'b1, WR_R,  2'd0, 1'b1, RD_R,  2'd0, 5'd0, 2,  22};
    vecs[4] = '{1'b1, 1'b1, RD_R,  2'd0, 1'b1, WR_R,  2'd0, 5'd0, 2,  12};
    vecs[5] = '{1'b0, 1'b0, RD_R,  2'd0, 1'b0, RD_R,  2'd0, 5'd4, 12, -1};
    vecs[6] = '{1'b1, 1'b1, WRA_R, 2'd2, 1'b1, WR_R,  2'd2, 5'd0, 2,  8};
    vecs[7] = '{1'b1, 1'b0, WR_R,  2'd1, 1'b0, WR_R,  2'd0, 5'd0, 16, 20};
    vecs[8] = '{1'b1, 1'b1, RDA_R, 2'd3, 1'b0, RD_R,  2'd3, 5'd0, 2,  17};

    drive_idle();
    do_reset(5'd0);
    @(negedge CK_t);
    check_reset_vals("rst");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Single miss: cas_idle profile around the strobe.
    do_reset(5'd0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CK_t);
      if (k == 0)  check("idle_c0",  int'(cas_idle), 1);
      if (k == 1)  check("idle_c1",  int'(cas_idle), 0);
      if (k == 16) check("idle_c16", int'(cas_idle), 0);
      if (k == 17) check("idle_c17", int'(cas_idle), 1);
      if (k == 8)  check("lvl_c8",   int'(q_level),  1);
      if (bus.cas_rdy) begin
        n++;
        check("miss_cyc", k, 16);
      end
      if (k == 0) drive_push(1'b0, RD_R, 2'd0); else drive_idle();
    end
    check("miss_strobes", n, 1);

    // Five write misses into a four-deep queue.
    do_reset(5'd0);
    strobe_cyc.delete();
    max_lvl = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CK_t);
      if (int'(q_level) > max_lvl) max_lvl = int'(q_level);
      if (k == 3) check("full_rdy_c3", int'(bus.act_ready), 1);
      if (k == 4) check("full_rdy_c4", int'(bus.act_ready), 0);
      if (k == 4) check("full_err_c4", int'(err), 0);
      if (k == 5) check("full_err_c5", int'(err), 1);
      if (bus.cas_rdy) strobe_cyc.push_back(k);
      if (k <= 4) drive_push(1'b0, WR_R, 2'd0); else drive_idle();
    end
    check("full_max_lvl", max_lvl, 4);
    check("full_strobes", strobe_cyc.size(), 4);
    exp_cyc = '{16, 22, 28, 34};
    for (int i = 0; i < 4 && i < strobe_cyc.size(); i++)
      check($sformatf("full_cyc%0d", i), strobe_cyc[i], exp_cyc[i]);
    check("full_err_end", int'(err), 1);
    check("full_idle_end", int'(cas_idle), 1);
    check("full_lvl_end", int'(q_level), 0);

    // Illegal request code is dropped.
    do_reset(5'd0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CK_t);
      if (bus.cas_rdy) n++;
      if (k == 2) check("ill_lvl", int'(q_level), 0);
      if (k == 0) drive_push(1'b1, 3'd5, 2'd1); else drive_idle();
    end
    check("ill_err", int'(err), 1);
    check("ill_strobes", n, 0);

    // Reset asserted mid-wait flushes the pending miss.
    do_reset(5'd0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge CK_t);
      if (k == 0) drive_push(1'b0, RD_R, 2'd0); else drive_idle();
    end
    check("mid_lvl_pre", int'(q_level), 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CK_t);
      if (bus.cas_rdy) n++;
    end
    check("mid_strobes", n, 0);
    check("mid_idle", int'(cas_idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_cas_sched.md
# ctrl_cas_sched

Parametrised CAS scheduler for the DDR4 controller. It sits between the ACT stage (`burst_act`) and the command encoder. It queues up to DEPTH pending column requests in ACT order and enforces three timing constraints per request: tRCD (minus AL) from its ACT, tCCD_S/tCCD_L by bank group, and the read-to-write / write-to-read turnaround. When a request's constraints are met it emits one `cas_rdy` strobe per request. Timing state is tracked per queue entry and per last issued CAS, so back-to-back ACTs to mixed bank groups and directions issue at the earliest legal cycle.

## Interface
Parameters:
- DEPTH, 4 — pending-request queue entries (≥2)
- BG_W, 2 — bank-group field width
- CNT_W, 7 — width of timing counters; all counters saturate at 2^CNT_W−1
- T_RCD, 16 — ACT-to-CAS, cycles
- T_CCD_S, 4 — CAS-to-CAS, different bank group
- T_CCD_L, 6 — CAS-to-CAS, same bank group
- T_WTR, 4 — write-to-read internal delay

Ports:
- CK_t  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- act_valid  in  1  ACT issued, or open-row hit, for one request this cycle
- act_hit  in  1  1 = row already open; no tRCD wait
- act_rw  in  3  request code: RD_R, RDA_R, WR_R or WRA_R (ddr_pkg)
- act_bg  in  BG_W  bank group of the request
- CL, CWL, AL  in  5 each  runtime latencies; AL < T_RCD
- BL  in  4  burst length (8 or 4)
- act_ready  out  1  queue can accept; registered
- cas_rdy  out  1  one-cycle issue strobe; registered
- cas_req  out  3  code of the issued request; valid while cas_rdy=1
- cas_bg  out  BG_W  bank group of the issued request; valid while cas_rdy=1
- cas_idle  out  1  queue empty and no strobe in flight
- q_level  out  $clog2(DEPTH+1)  occupied entries
- err  out  1  sticky: push dropped (queue full or illegal code)

## Operation
- Reset values: act_ready=1, cas_rdy=0, cas_req=0, cas_bg=0, cas_idle=1, q_level=0, err=0. History is marked "no previous CAS". Reset mid-operation flushes the queue immediately (asynchronously); no strobe follows release without a new act_valid.
- Push: when act_valid=1 and act_ready=1, the entry {act_rw, act_bg, eligible-cycle} is appended.
  - Eligible cycle for a miss: push cycle + max(T_RCD−AL, 2).
  - Eligible cycle for a hit: push cycle + 2.
- Dropped pushes: act_valid while act_ready=0, or an act_rw that is not one of the four codes. The request is dropped, err sets, and the queue is unchanged.
- Issue is strictly in order, head entry only. The head issues at cycle u when u ≥ its eligible cycle and u − u_prev ≥ gap, where u_prev is the last cas_rdy cycle. gap is:
  - no previous CAS: 0
  - same direction, same bg: T_CCD_L
  - same direction, different bg: T_CCD_S
  - read→write: CL − CWL + BL/2 + 2
  - write→read: CWL + BL/2 + T_WTR
- Gap arithmetic: compute gap signed in CNT_W+1 bits, then clamp to the range [T_CCD_S, 2^CNT_W−1]. The elapsed-since-last-CAS counter saturates; a saturated counter satisfies any gap.
- Direction classes: RD_R and RDA_R are reads; WR_R and WRA_R are writes. The auto-precharge variant does not affect spacing.
- State machine:
  - CAS_IDLE: queue empty. Goes to CAS_WAIT on push.
  - CAS_WAIT: head pending. Goes to CAS_CMD when the head is eligible.
  - CAS_CMD: cas_rdy=1 for exactly one cycle and the head pops. Goes to CAS_WAIT if entries remain, otherwise to CAS_IDLE.
- Queue: simultaneous push and pop are allowed, and q_level is net of both. act_ready = (q_level < DEPTH) as registered; a pop in the same cycle does not raise it early. Pointers wrap modulo DEPTH.
- cas_idle = (state == CAS_IDLE) and cas_rdy = 0.

## Timing
- Cycle numbering: act_valid is sampled at the rising edge ending cycle t. The earliest cas_rdy is cycle t+2 for a hit and cycle t+T_RCD−AL for a miss.
- Back-to-back strobes are separated by at least T_CCD_S cycles.
- The tRCD countdown of queued entries runs while earlier entries wait. Queue waiting time overlaps tRCD and does not add to it.
- CL/CWL/AL/BL must only change while cas_idle=1. Behaviour after a change with a non-empty queue is undefined.

## Test plan
Defaults for all scenarios: CL=16, CWL=12, AL=0, BL=8.
- Reset, then miss RD_R bg0 at cycle 0 -> cas_rdy only at cycle 16 with cas_req=RD_R; cas_idle=0 for cycles 1–16 and 1 from cycle 17.
- Hits RD_R bg0 at cycles 0 and 1 -> cas_rdy at cycles 2 and 8. With the second request on bg1 -> cas_rdy at 2 and 6.
- Hit WR_R then hit RD_R, same bg, at cycles 0 and 1 -> cas_rdy at 2 and 22 (12+4+4). Hit RD_R then WR_R -> cas_rdy at 2 and 12 (16−12+4+2).
- Five miss WR_R bg0 on cycles 0–4, DEPTH=4 -> act_ready=0 at cycle 4, fifth push dropped, err=1, q_level peaks at 4; cas_rdy at 16, 22, 28, 34.
- AL=4, miss RD_R at cycle 0 -> cas_rdy at cycle 12.
- Scenario 1 with reset_n low at cycle 10 -> all outputs at reset values; no cas_rdy within 40 cycles after release.
